// File: rtl/intbus_arbiter.sv
`timescale 1ns/1ps
// intbus_arbiter: N-master to 1-slave register-bus arbiter.
// Round-robin grant, one outstanding transaction, read timeout so that a
// silent slave cannot hang the bus.
// Optional statistics (tmo_cnt, grant_cnt, stat_clr) are built only when
// the macro INTBUS_ARB_STAT_EN is defined.
module intbus_arbiter #(
  parameter int N_MASTERS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEADBEEF,
  localparam int ID_W = $clog2(N_MASTERS)
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef INTBUS_ARB_STAT_EN
  input  logic                             stat_clr,
  output logic [15:0]                      tmo_cnt,
  output logic [N_MASTERS*16-1:0]          grant_cnt,
`endif
  input  logic [N_MASTERS-1:0]             m_wr,
  input  logic [N_MASTERS-1:0]             m_rd,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  output logic [N_MASTERS-1:0]             m_ack,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_tmo,
  output logic                             s_wr,
  output logic                             s_rd,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  input  logic                             s_rvalid,
  output logic                             busy,
  output logic [ID_W-1:0]                  grant_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_WAIT,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]       rr_ptr;
  logic [15:0]           wait_cnt;
  logic                  tmo_flag;
  logic                  timeout_hit;

  // Per-master views of the flattened address / write-data buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [N_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [N_MASTERS];

  // Round-robin pick results.
  logic                  pick_valid;
  logic                  pick_wr;
  logic [ID_W-1:0]       pick_id;
  logic [ID_W-1:0]       scan_id;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign timeout_hit = (wait_cnt == 16'(RD_TIMEOUT));

  // Round-robin search from rr_ptr upward with wrap; the nearest requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_valid = 1'b0;
    pick_wr    = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    // Scan from the farthest candidate down so the nearest one overwrites last.
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      scan_id = ID_W'((int'(rr_ptr) + k) % N_MASTERS);
      if (m_wr[scan_id] || m_rd[scan_id]) begin
        pick_valid = 1'b1;
        pick_id    = scan_id;
        pick_wr    = m_wr[scan_id];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state decode and state-derived strobes.
  always_comb begin
    state_d = state_q;
    s_wr    = 1'b0;
    s_rd    = 1'b0;
    m_ack   = '0;
    m_tmo   = 1'b0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: if (pick_valid) state_d = pick_wr ? S_WR : S_RD;
      S_WR: begin
        s_wr    = 1'b1;
        state_d = S_ACK;
      end
      S_RD: begin
        s_rd    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (s_rvalid || timeout_hit) state_d = S_ACK;
      S_ACK: begin
        m_ack   = N_MASTERS'(1) << grant_id;
        m_tmo   = tmo_flag;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: grant capture, slave request registers, read wait and pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m_rdata  <= '0;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      tmo_flag <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            s_addr   <= addr_arr[pick_id];
            s_wdata  <= wdata_arr[pick_id];
            tmo_flag <= 1'b0;
          end
        end
        S_RD: wait_cnt <= '0;
        S_WAIT: begin
          // Data arriving on the last allowed cycle still wins over the timeout.
          if (s_rvalid) begin
            m_rdata <= s_rdata;
          end else if (timeout_hit) begin
            m_rdata  <= TIMEOUT_DATA;
            tmo_flag <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_ACK: begin
          // The master just served drops to lowest priority.
          rr_ptr <= (grant_id == ID_W'(N_MASTERS - 1)) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef INTBUS_ARB_STAT_EN
  logic [15:0] grant_cnt_arr [N_MASTERS];

  // Saturating timeout and per-master completion counters; stat_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this small counter array is reset explicitly because software reads it
    // directly; a large storage array would normally be left unreset.
    if (rst) begin
      tmo_cnt <= '0;
      for (int i = 0; i < N_MASTERS; i++) grant_cnt_arr[i] <= '0;
    end else if (stat_clr) begin
      tmo_cnt <= '0;
      for (int i = 0; i < N_MASTERS; i++) grant_cnt_arr[i] <= '0;
    end else begin
      if (state_q == S_WAIT && !s_rvalid && timeout_hit && tmo_cnt != 16'hFFFF)
        tmo_cnt <= tmo_cnt + 16'd1;
      if (state_q == S_ACK && grant_cnt_arr[grant_id] != 16'hFFFF)
        grant_cnt_arr[grant_id] <= grant_cnt_arr[grant_id] + 16'd1;
    end
  end

  // Flatten the per-master counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_MASTERS; i++) grant_cnt[i*16 +: 16] = grant_cnt_arr[i];
  end
`else
  // Statistics disabled: no counters or extra ports are built.
`endif

endmodule

// File: tb/tb_intbus_arbiter.sv
`timescale 1ns/1ps
// tb_intbus_arbiter: directed, table-driven bench for intbus_arbiter
// (4 masters, RD_TIMEOUT = 8), plus hand-written multi-cycle sequences.
module tb_intbus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_wr, m_rd, m_ack;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]   s_addr;
  logic            m_tmo, s_wr, s_rd, s_rvalid, busy;
  logic [1:0]      grant_id;
`ifdef INTBUS_ARB_STAT_EN
  logic            stat_clr;
  logic [15:0]     tmo_cnt;
  logic [N*16-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  intbus_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RD_TIMEOUT(TMO), .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef INTBUS_ARB_STAT_EN
    .stat_clr(stat_clr), .tmo_cnt(tmo_cnt), .grant_cnt(grant_cnt),
`endif
    .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_tmo(m_tmo),
    .s_wr(s_wr), .s_rd(s_rd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic [3:0]  wr, rd;
    int          mid;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rdata;
    logic        e_swr, e_srd;
    logic [3:0]  e_ack;
    logic        e_tmo, e_busy;
    logic [1:0]  e_gid;
    logic [15:0] e_saddr;
    logic [31:0] e_swdata, e_rdata;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(
    input logic [3:0] wr, input logic [3:0] rd, input int mid,
    input logic [15:0] addr, input logic [31:0] wdata,
    input logic rv, input logic [31:0] rdata,
    input logic e_swr, input logic e_srd, input logic [3:0] e_ack,
    input logic e_tmo, input logic e_busy, input logic [1:0] e_gid,
    input logic [15:0] e_saddr, input logic [31:0] e_swdata, input logic [31:0] e_rdata);
    vec_t v;
    v.wr = wr; v.rd = rd; v.mid = mid; v.addr = addr; v.wdata = wdata;
    v.rv = rv; v.rdata = rdata;
    v.e_swr = e_swr; v.e_srd = e_srd; v.e_ack = e_ack; v.e_tmo = e_tmo;
    v.e_busy = e_busy; v.e_gid = e_gid; v.e_saddr = e_saddr;
    v.e_swdata = e_swdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [15:0] addr, input logic [31:0] wdata);
    m_addr[i*AW +: AW]  = addr;
    m_wdata[i*DW +: DW] = wdata;
  endtask

  task automatic clear_inputs();
    m_wr = '0; m_rd = '0; s_rvalid = 1'b0; s_rdata = '0;
    for (int i = 0; i < N; i++) set_master(i, 16'hF000 | 16'(i), 32'hBAD0_0000 | 32'(i));
`ifdef INTBUS_ARB_STAT_EN
    stat_clr = 1'b0;
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acks [N];
    int n_grants;
    int ack_at;
    logic [3:0]  ack_vec;
    logic [31:0] ack_data;
    logic        ack_tmo;
    logic [1:0]  ack_gid;
    logic [31:0] slave_word;

    // Single write by master 2, then single read by master 1 with a
    // 3-cycle slave delay, a stray request that drops before grant,
    // and an s_rvalid outside WAIT that must be ignored.
    vt[0] = mk(4'b0100, 4'b0000, 2, 16'h0010, 32'hA5A5A5A5, 1'b0, 32'h0,
               1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 16'h0010, 32'hA5A5A5A5, 32'h0);
    vt[1] = mk(4'b0100, 4'b0000, 2, 16'h0010, 32'hA5A5A5A5, 1'b0, 32'h0,
               1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 16'h0010, 32'hA5A5A5A5, 32'h0);
    vt[2] = mk(4'b0100, 4'b0000, 2, 16'h0010, 32'hA5A5A5A5, 1'b0, 32'h0,
               1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 16'h0010, 32'hA5A5A5A5, 32'h0);
    vt[3] = mk(4'b0000, 4'b0010, 1, 16'h0004, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 16'h0004, 32'h0, 32'h0);
    vt[4] = mk(4'b0000, 4'b0011, 1, 16'h0004, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 16'h0004, 32'h0, 32'h0);
    vt[5] = mk(4'b0000, 4'b0011, 1, 16'h0004, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 16'h0004, 32'h0, 32'h0);
    vt[6] = mk(4'b0000, 4'b0010, 1, 16'h0004, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 16'h0004, 32'h0, 32'h0);
    vt[7] = mk(4'b0000, 4'b0010, 1, 16'h0004, 32'h0, 1'b1, 32'h12345678,
               1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 16'h0004, 32'h0, 32'h12345678);
    vt[8] = mk(4'b0000, 4'b0010, 1, 16'h0004, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 16'h0004, 32'h0, 32'h12345678);
    vt[9] = mk(4'b0000, 4'b0000, 1, 16'h0004, 32'h0, 1'b1, 32'hFFFFFFFF,
               1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 16'h0004, 32'h0, 32'h12345678);

    // ---- Reset state ----
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    check("rst_s_wr",    32'(s_wr),     32'h0);
    check("rst_s_rd",    32'(s_rd),     32'h0);
    check("rst_m_ack",   32'(m_ack),    32'h0);
    check("rst_m_tmo",   32'(m_tmo),    32'h0);
    check("rst_busy",    32'(busy),     32'h0);
    check("rst_grant",   32'(grant_id), 32'h0);
    check("rst_s_addr",  32'(s_addr),   32'h0);
    check("rst_s_wdata", s_wdata,       32'h0);
    check("rst_m_rdata", m_rdata,       32'h0);
    rst = 1'b0;

    // ---- Table-driven single write / single read ----
    for (int k = 0; k < 10; k++) begin
      m_wr = vt[k].wr;
      m_rd = vt[k].rd;
      for (int i = 0; i < N; i++)
        if (i == vt[k].mid) set_master(i, vt[k].addr, vt[k].wdata);
        else set_master(i, 16'hF000 | 16'(i), 32'hBAD0_0000 | 32'(i));
      s_rvalid = vt[k].rv;
      s_rdata  = vt[k].rdata;
      tick();
      check($sformatf("v%0d_s_wr", k),    32'(s_wr),     32'(vt[k].e_swr));
      check($sformatf("v%0d_s_rd", k),    32'(s_rd),     32'(vt[k].e_srd));
      check($sformatf("v%0d_m_ack", k),   32'(m_ack),    32'(vt[k].e_ack));
      check($sformatf("v%0d_m_tmo", k),   32'(m_tmo),    32'(vt[k].e_tmo));
      check($sformatf("v%0d_busy", k),    32'(busy),     32'(vt[k].e_busy));
      check($sformatf("v%0d_grant", k),   32'(grant_id), 32'(vt[k].e_gid));
      check($sformatf("v%0d_s_addr", k),  32'(s_addr),   32'(vt[k].e_saddr));
      check($sformatf("v%0d_s_wdata", k), s_wdata,       vt[k].e_swdata);
      check($sformatf("v%0d_m_rdata", k), m_rdata,       vt[k].e_rdata);
    end

    // ---- Round-robin: all four masters write continuously ----
    reset_dut();
    for (int i = 0; i < N; i++) begin
      set_master(i, 16'(i * 256), 32'hC000_0000 | 32'(i));
      acks[i] = 0;
    end
    m_wr = 4'b1111;
    n_grants = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (s_wr) begin
        check($sformatf("rr_grant%0d", n_grants), 32'(grant_id), 32'(n_grants % N));
        check($sformatf("rr_addr%0d", n_grants),  32'(s_addr),   32'((n_grants % N) * 256));
        check($sformatf("rr_wdata%0d", n_grants), s_wdata, 32'hC000_0000 | 32'(n_grants % N));
        n_grants++;
      end
      if (c < 12)
        for (int i = 0; i < N; i++) if (m_ack[i]) acks[i]++;
    end
    check("rr_grant_count", 32'(n_grants), 32'd5);
    for (int i = 0; i < N; i++) check($sformatf("rr_acks_m%0d", i), 32'(acks[i]), 32'd1);

    // ---- Read timeout: slave never answers ----
    reset_dut();
    set_master(3, 16'h0030, 32'h0);
    m_rd = 4'b1000;
    ack_at = -1; ack_vec = '0; ack_data = '0; ack_tmo = 1'b0; ack_gid = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (m_ack != 4'b0000) begin
        ack_at = c; ack_vec = m_ack; ack_data = m_rdata; ack_tmo = m_tmo; ack_gid = grant_id;
        break;
      end
    end
    check("tmo_ack_cycle", 32'(ack_at),  32'(TMO + 2));
    check("tmo_ack_vec",   32'(ack_vec), 32'b1000);
    check("tmo_rdata",     ack_data,     32'hDEADBEEF);
    check("tmo_flag",      32'(ack_tmo), 32'h1);
    check("tmo_grant",     32'(ack_gid), 32'd3);
`ifdef INTBUS_ARB_STAT_EN
    check("tmo_cnt_one", 32'(tmo_cnt), 32'd1);
`endif
    tick();
    m_rd = '0;
    check("tmo_after_m_tmo", 32'(m_tmo), 32'h0);
    check("tmo_after_busy",  32'(busy),  32'h0);
    check("tmo_rdata_hold",  m_rdata,    32'hDEADBEEF);
`ifdef INTBUS_ARB_STAT_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("tmo_cnt_clr", 32'(tmo_cnt), 32'd0);
`endif

    // ---- Reset in the middle of a read ----
    reset_dut();
    set_master(1, 16'h0044, 32'h0);
    m_rd = 4'b0010;
    tick();
    check("rmr_s_rd", 32'(s_rd), 32'h1);
    tick();
    tick();
    check("rmr_busy_wait", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rmr_s_rd_rst",  32'(s_rd),     32'h0);
    check("rmr_ack_rst",   32'(m_ack),    32'h0);
    check("rmr_busy_rst",  32'(busy),     32'h0);
    check("rmr_grant_rst", 32'(grant_id), 32'h0);
    m_rd = 4'b1000;
    set_master(3, 16'h0033, 32'h0);
    tick();
    check("rmr_busy_held", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    check("rmr_new_s_rd",  32'(s_rd),     32'h1);
    check("rmr_new_grant", 32'(grant_id), 32'd3);
    check("rmr_new_addr",  32'(s_addr),   32'h0033);

    // ---- Same master with write and read together ----
    reset_dut();
    set_master(0, 16'h0008, 32'h5);
    m_wr = 4'b0001;
    m_rd = 4'b0001;
    slave_word = '0;
    tick();
    check("wr_rd_s_wr",  32'(s_wr),   32'h1);
    check("wr_rd_s_rd0", 32'(s_rd),   32'h0);
    check("wr_rd_waddr", 32'(s_addr), 32'h0008);
    if (s_wr && s_addr == 16'h0008) slave_word = s_wdata;
    tick();
    check("wr_rd_wack",  32'(m_ack),  32'b0001);
    tick();
    m_wr = 4'b0000;
    tick();
    check("wr_rd_s_rd",   32'(s_rd),     32'h1);
    check("wr_rd_rgrant", 32'(grant_id), 32'd0);
    check("wr_rd_raddr",  32'(s_addr),   32'h0008);
    tick();
    s_rvalid = 1'b1;
    s_rdata  = slave_word;
    tick();
    s_rvalid = 1'b0;
    check("wr_rd_rack",   32'(m_ack),  32'b0001);
    check("wr_rd_rdata",  m_rdata,     32'h5);
    check("wr_rd_rtmo",   32'(m_tmo),  32'h0);
    tick();
    m_rd = 4'b0000;
    check("wr_rd_idle",   32'(busy),   32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intbus_arbiter.md
Name: intbus_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the internal register bus.
- Lets several bus masters (CPU bridges, DMA, debug) share one register-file slave.
- Uses round-robin grant, a single outstanding transaction, and a read timeout so a silent slave cannot hang the bus.
- Sits between the per-master bus bridges and the shared register-file decode.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- ADDR_WIDTH, 16, address width in bits.
- DATA_WIDTH, 32, data width in bits.
- RD_TIMEOUT, 255, maximum cycles to wait for s_rvalid after s_rd (1..65535).
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned when a read times out.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- m_wr  in  N_MASTERS  per-master write request, held until acked
- m_rd  in  N_MASTERS  per-master read request, held until acked
- m_addr  in  N_MASTERS*ADDR_WIDTH  per-master address; master i uses slice i
- m_wdata  in  N_MASTERS*DATA_WIDTH  per-master write data
- m_ack  out  N_MASTERS  one-cycle completion pulse to the granted master
- m_rdata  out  DATA_WIDTH  read data, valid while the matching m_ack bit is high
- m_tmo  out  1  high with m_ack when the completed read timed out
- s_wr  out  1  slave write strobe, one cycle
- s_rd  out  1  slave read strobe, one cycle
- s_addr  out  ADDR_WIDTH  slave address, registered
- s_wdata  out  DATA_WIDTH  slave write data, registered
- s_rdata  in  DATA_WIDTH  slave read data
- s_rvalid  in  1  slave read data valid
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(N_MASTERS)  index of the current or last granted master

Behaviour:
- Reset (async, immediate): state=IDLE; every output 0; RR pointer=0; timeout counter=0. Reset mid-transaction aborts it; no ack is issued.
- Handshake: a master holds wr/rd, addr and wdata stable until the edge that samples its m_ack=1. It may present a new request from the next cycle.
- FSM states:
  - IDLE: if any (m_wr|m_rd) is set, pick a master round-robin, searching from pointer upward with wrap. Register grant_id, s_addr and s_wdata. Go to WR if m_wr is set, else RD.
  - WR: s_wr=1 for one cycle -> ACK.
  - RD: s_rd=1 for one cycle, clear the counter -> WAIT.
  - WAIT: on s_rvalid, capture s_rdata -> ACK. If the counter reaches RD_TIMEOUT, load TIMEOUT_DATA and set the tmo flag -> ACK. Otherwise increment the counter.
  - ACK: m_ack[grant_id]=1, m_rdata valid, m_tmo=flag. Pointer=grant_id+1, wrapping at N_MASTERS. -> IDLE.
- Latency from a request sampled in IDLE at edge t:
  - Write: s_wr at t+1, m_ack at t+2. Back-to-back writes complete one every 3 cycles.
  - Read: s_rd at t+1. s_rvalid is accepted from t+2 onward. m_ack follows the cycle after s_rvalid.
- s_rvalid outside WAIT is ignored.
- Same master with wr and rd both high: the write is served first, the read is served on a later grant.
- Round-robin fairness: a master that just completed has the lowest priority next. Any requester waits at most N_MASTERS-1 grants.
- Requests that drop before grant are not served, without error.
- m_rdata holds its value between acks. s_addr and s_wdata hold the last granted values.

Optional Feature:
- Macro INTBUS_ARB_STAT_EN.
- Defined:
  - Adds output tmo_cnt, 16 bits: saturating count of read timeouts.
  - Adds input stat_clr, 1 bit: synchronous clear of tmo_cnt, with priority over increment in the same cycle.
  - Adds output grant_cnt, N_MASTERS*16 bits: saturating per-master completed-transaction count, also cleared by stat_clr.
  - All of these reset to 0.
- Undefined: none of these ports or counters exist; the core behaviour is identical.

Test Plan:
- Single write, N_MASTERS=4: master 2 writes addr 0x0010 data 0xA5A5A5A5 -> s_wr at t+1 with those values; m_ack=4'b0100 at t+2; busy high for t+1..t+2.
- Single read: master 1 reads 0x0004, slave returns 0x12345678 three cycles after s_rd -> m_ack[1] and m_rdata=0x12345678 the cycle after s_rvalid; m_tmo=0.
- Round-robin: all 4 masters request writes continuously from reset -> grant order 0,1,2,3,0; each master completes exactly once per 12 cycles.
- Timeout: RD_TIMEOUT=8, slave never asserts s_rvalid -> m_ack with m_rdata=0xDEADBEEF and m_tmo=1; with INTBUS_ARB_STAT_EN, tmo_cnt=1.
- Reset mid-read: rst asserted in WAIT -> s_rd, m_ack and busy are 0 immediately; after release, a new request from master 3 is granted first (pointer=0 search finds 3 when only master 3 requests).
- Wr+rd together: master 0 asserts both, write 0x5 to 0x8 then read 0x8 -> write acked first, then the read returns 0x5 on a separate m_ack.
